// File: rtl/commutation_sched.sv
// commutation_sched: six-step BLDC commutation scheduler.
// Synchronises the Hall inputs and generates the PWM. The Hall code is latched once
// per PWM period. RUN/BRAKE/FAULT are sequenced at period boundaries. The three
// phase gate request pairs are driven from registers.
// Optional feature macro: COMM_CNT_EN counts accepted commutations on comm_cnt.
// When it is undefined, comm_cnt is tied to zero.
module commutation_sched #(
    parameter int PWM_W     = 11,
    parameter int FAULT_PER = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hallGrn,
    input  logic             hallYlw,
    input  logic             hallBlu,
    input  logic [PWM_W-1:0] duty,
    input  logic             en,
    input  logic             brake_n,
    output logic             highGrn,
    output logic             lowGrn,
    output logic             highYlw,
    output logic             lowYlw,
    output logic             highBlu,
    output logic             lowBlu,
    output logic             PWM_synch,
    output logic             fault,
    output logic [15:0]      comm_cnt
);

    localparam int INV_W = $clog2(FAULT_PER + 1);
    localparam logic [INV_W-1:0] INV_MAX = INV_W'(FAULT_PER);

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;
    typedef enum logic [1:0] {PH_Z, PH_F, PH_R, PH_BRK} phase_t;

    logic [2:0]       hall_meta;
    logic [2:0]       hall_sync;
    logic [2:0]       rot_state;
    logic [PWM_W-1:0] cnt;
    logic             cmp;
    state_t           state, state_nxt;
    logic [INV_W-1:0] inv_cnt, inv_nxt, inv_inc;
    phase_t           ph_g, ph_y, ph_b;

    // 000 and 111 cannot occur with correctly spaced Hall sensors
    function automatic logic code_valid(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    // phase state plus PWM level -> {hi, lo}; no encoding ever yields 2'b11
    function automatic logic [1:0] enc(input phase_t p, input logic pwm);
        case (p)
            PH_F:    return {pwm, ~pwm};
            PH_R:    return {~pwm, pwm};
            PH_BRK:  return {1'b0, pwm};
            default: return 2'b00;
        endcase
    endfunction

    // two-flop synchroniser for the asynchronous Hall inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_meta <= 3'b000;
            hall_sync <= 3'b000;
        end else begin
            hall_meta <= {hallGrn, hallYlw, hallBlu};
            hall_sync <= hall_meta;
        end
    end

    // free-running PWM counter; the period ends on the all-ones count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + 1'b1;
    end

    assign PWM_synch = (cnt == '1);
    assign cmp       = (cnt < duty);

    // rotor position only moves at period boundaries so a PWM pulse is never cut short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rot_state <= 3'b000;
        else if (PWM_synch) rot_state <= hall_sync;
    end

    // state and invalid-code counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            inv_cnt <= '0;
        end else begin
            state   <= state_nxt;
            inv_cnt <= inv_nxt;
        end
    end

    // next-state: en low acts at once, everything else waits for a boundary
    always_comb begin
        state_nxt = state;
        inv_nxt   = inv_cnt;
        inv_inc   = (inv_cnt < INV_MAX) ? inv_cnt + 1'b1 : inv_cnt;
        if (!en) begin
            state_nxt = IDLE;
            inv_nxt   = '0;
        end else if (PWM_synch) begin
            if (code_valid(hall_sync)) inv_nxt = '0;
            case (state)
                IDLE:  state_nxt = brake_n ? RUN : BRAKE;
                RUN: begin
                    if (!brake_n) begin
                        state_nxt = BRAKE;
                    end else if (!code_valid(hall_sync)) begin
                        inv_nxt = inv_inc;
                        if (inv_inc == INV_MAX) state_nxt = FAULT;
                    end
                end
                BRAKE: if (brake_n) state_nxt = RUN;
                default: state_nxt = FAULT;
            endcase
        end
    end

    assign fault = (state == FAULT);

    // per-phase drive selection; an invalid latched code floats every phase
    always_comb begin
        ph_g = PH_Z;
        ph_y = PH_Z;
        ph_b = PH_Z;
        case (state)
            RUN: begin
                case (rot_state)
                    3'b101: begin ph_g = PH_F; ph_y = PH_R; end
                    3'b100: begin ph_g = PH_F; ph_b = PH_R; end
                    3'b110: begin ph_y = PH_F; ph_b = PH_R; end
                    3'b010: begin ph_g = PH_R; ph_y = PH_F; end
                    3'b011: begin ph_g = PH_R; ph_b = PH_F; end
                    3'b001: begin ph_y = PH_R; ph_b = PH_F; end
                    default: ;
                endcase
            end
            BRAKE: begin
                ph_g = PH_BRK;
                ph_y = PH_BRK;
                ph_b = PH_BRK;
            end
            default: ;
        endcase
    end

    // registered gate requests, one clock after the PWM compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {highGrn, lowGrn} <= 2'b00;
            {highYlw, lowYlw} <= 2'b00;
            {highBlu, lowBlu} <= 2'b00;
        end else if (!en) begin
            {highGrn, lowGrn} <= 2'b00;
            {highYlw, lowYlw} <= 2'b00;
            {highBlu, lowBlu} <= 2'b00;
        end else begin
            {highGrn, lowGrn} <= enc(ph_g, cmp);
            {highYlw, lowYlw} <= enc(ph_y, cmp);
            {highBlu, lowBlu} <= enc(ph_b, cmp);
        end
    end

`ifdef COMM_CNT_EN
    logic [2:0] last_code;

    // count boundaries in RUN where a valid code differs from the last valid one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comm_cnt  <= 16'h0000;
            last_code <= 3'b000;
        end else if (!en) begin
            comm_cnt  <= 16'h0000;
            last_code <= 3'b000;
        end else if (PWM_synch && state == RUN && code_valid(hall_sync)) begin
            last_code <= hall_sync;
            if (hall_sync != last_code) comm_cnt <= comm_cnt + 16'd1;
        end
    end
`else
    assign comm_cnt = 16'h0000;
`endif

endmodule
